req_ack_pulse_tx: RTL and testbench
===================================

// Module: req_ack_pulse_tx
// PURPOSE
//  Transmit side of a 4-phase req/ack crossing: turns single-cycle event pulses in the clk
//  domain into level handshakes on req_out toward a foreign-domain receiver that returns
//  ack_in. Queues events as a count while a handshake is in flight. Flags overflow and
//  ack timeouts. ack_in is double-flopped internally; the receiver double-flops req_out.
// PARAMETERS
//  MAX_PENDING  7     max queued, not-yet-launched events (1..2^PW-1)
//  PW           3     width of pending counter
//  TIMEOUT      1000  clk cycles allowed in REQ_HI waiting for ack; 0 = timeout disabled
//  TW           10    width of timeout counter (must hold TIMEOUT)
// PORTS
//  clk          in   1   sole clock, all logic posedge
//  reset_n      in   1   synchronous reset, active low
//  in_pulse     in   1   event strobe, 1 clk wide per event, clk domain
//  ack_in       in   1   receiver ack, asynchronous, 2-FF synced internally to ack_s
//  req_out      out  1   registered handshake request level
//  busy         out  1   1 when state != IDLE
//  pending      out  PW  queued events not yet launched
//  done_pulse   out  1   1-clk strobe: ack_s seen high, handshake accepted
//  overflow     out  1   1-clk strobe: event dropped, queue full
//  timeout_err  out  1   1-clk strobe: REQ_HI aborted on timeout
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=IDLE, req_out=0, pending=0, sync FFs=0, timer=0, all
//    strobes 0. Reset mid-handshake drops req_out next edge; queued events discarded.
//  - ack_s = ack_in after 2 clk flops; FSM uses only ack_s.
//  - "launch" = transition into REQ_HI; req_out=1 the cycle after the launch decision.
//  - IDLE: if in_pulse or pending>0 -> REQ_HI (launch). In_pulse consumed directly when
//    pending=0 (pending stays 0); else the oldest queued event is launched, pending-1.
//  - REQ_HI (req_out=1): ack_s=1 -> REQ_LO, req_out=0, done_pulse=1 same edge.
//    timer==TIMEOUT-1 and ack_s=0 (TIMEOUT>0) -> ABORT, req_out=0, timeout_err=1; event lost.
//    ack_s=1 and timeout same cycle: ack wins.
//  - REQ_LO (req_out=0): ack_s=0 -> REQ_HI if pending>0 or in_pulse (launch), else IDLE.
//    No timeout in REQ_LO.
//  - ABORT (req_out=0): ack_s=0 -> IDLE. Never launches directly.
//  - Timer: cleared on every entry to REQ_HI, +1 per cycle in REQ_HI, no wrap.
//  - Pending: net = +in_pulse(if not consumed directly) -launch(from queue); simultaneous
//    +1/-1 leaves it unchanged. At pending==MAX_PENDING with in_pulse and no decrement:
//    event dropped, overflow=1 for 1 clk, pending holds. Never wraps below 0.
//  - Min handshake period: req rise -> req rise = 2+2 sync + receiver latency; back-to-back
//    queued events relaunch the cycle ack_s falls.
//  - busy is combinational from state; req_out, strobes are registered.
// TESTING
//  1 Single event: reset, in_pulse@c0, receiver acks after 3 clk -> req_out=1@c1, done_pulse
//    once, req_out low, return to IDLE; pending stays 0 throughout.
//  2 Burst: 4 in_pulse on consecutive clk while ack held low -> pending=3 after burst;
//    4 done_pulses total, pending decrements 3->2->1->0 on each relaunch.
//  3 Overflow: MAX_PENDING=7, 9 pulses during stalled REQ_HI (TIMEOUT=0) -> pending=7,
//    exactly 1 overflow strobe (1st consumed, 7 queued, 9th dropped).
//  4 Timeout: TIMEOUT=20, ack never rises -> req_out falls 20 clk after launch, timeout_err
//    once, state ABORT->IDLE, no done_pulse.
//  5 Ack vs timeout same cycle: ack_s rises on cycle TIMEOUT-1 -> done_pulse=1, timeout_err=0.
//  6 Reset mid-op: reset_n low during REQ_HI with pending=2 -> next edge req_out=0, pending=0,
//    busy=0; post-reset in_pulse launches normally.

Source files
------------

// File: rtl/req_ack_pulse_tx.sv
`default_nettype none
// ============================================================================
//  Module      : req_ack_pulse_tx
//  Description : Transmit side of a 4-phase req/ack clock-domain crossing.
//                Converts single-cycle event pulses into level handshakes on
//                req_out. Events arriving while a handshake is in flight are
//                queued as a count. Reports overflow and ack timeouts.
//
//  Ports
//    clk          in   1    sole clock, all logic on posedge
//    reset_n      in   1    synchronous reset, active low
//    in_pulse     in   1    event strobe, one clk wide per event
//    ack_in       in   1    receiver ack, asynchronous (2-FF synced to ack_s)
//    req_out      out  1    registered handshake request level
//    busy         out  1    high whenever the FSM is not idle
//    pending      out  PW   queued events not yet launched
//    done_pulse   out  1    1-clk strobe: handshake acknowledged
//    overflow     out  1    1-clk strobe: event dropped, queue full
//    timeout_err  out  1    1-clk strobe: request aborted on ack timeout
//
//  Revision    : 1.0 - initial release
// ============================================================================
module req_ack_pulse_tx #(
    parameter int MAX_PENDING = 7,
    parameter int PW          = 3,
    parameter int TIMEOUT     = 1000,
    parameter int TW          = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_pulse,
    input  logic          ack_in,
    output logic          req_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          done_pulse,
    output logic          overflow,
    output logic          timeout_err
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_req_hi = 2'd1;
    localparam logic [1:0] c_st_req_lo = 2'd2;
    localparam logic [1:0] c_st_abort  = 2'd3;

    // Timer value at which REQ_HI gives up; only meaningful when TIMEOUT > 0.
    localparam logic          c_tmo_en   = (TIMEOUT > 0);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] c_pend_max = PW'(MAX_PENDING);

    logic          r_ack_meta;
    logic          r_ack_s;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [PW-1:0] r_pending;
    logic          r_req;
    logic          r_done;
    logic          r_ovf;
    logic          r_tmo;

    logic [1:0]    w_state_d;
    logic [TW-1:0] w_timer_d;
    logic [PW-1:0] w_pending_d;
    logic          w_req_d;
    logic          w_done_d;
    logic          w_ovf_d;
    logic          w_tmo_d;
    logic          w_have_work;
    logic          w_launch;
    logic          w_direct;
    logic          w_inc;
    logic          w_dec;

    always_comb begin
        w_state_d   = r_state;
        w_timer_d   = r_timer;
        w_req_d     = r_req;
        w_done_d    = 1'b0;
        w_ovf_d     = 1'b0;
        w_tmo_d     = 1'b0;
        w_launch    = 1'b0;
        w_have_work = in_pulse || (r_pending != '0);

        case (r_state)
            c_st_idle: begin
                if (w_have_work) begin
                    w_launch = 1'b1;
                end
            end
            c_st_req_hi: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (r_ack_s) begin
                    w_state_d = c_st_req_lo;
                    w_req_d   = 1'b0;
                    w_done_d  = 1'b1;
                end else if (c_tmo_en && (r_timer == c_tmo_last)) begin
                    w_state_d = c_st_abort;
                    w_req_d   = 1'b0;
                    w_tmo_d   = 1'b1;
                end else if (r_timer != '1) begin
                    w_timer_d = r_timer + TW'(1);
                end
            end
            c_st_req_lo: begin
                // Back-to-back relaunch happens the cycle ack_s falls.
                if (!r_ack_s) begin
                    if (w_have_work) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state_d = c_st_idle;
                    end
                end
            end
            c_st_abort: begin
                if (!r_ack_s) begin
                    w_state_d = c_st_idle;
                end
            end
        endcase

        if (w_launch) begin
            w_state_d = c_st_req_hi;
            w_req_d   = 1'b1;
            w_timer_d = '0;
        end

        // A launch with an empty queue consumes the incoming pulse directly;
        // otherwise the oldest queued event goes and the new pulse is queued.
        w_direct = w_launch && (r_pending == '0);
        w_dec    = w_launch && (r_pending != '0);
        w_inc    = in_pulse && !w_direct;

        w_pending_d = r_pending;
        if (w_inc && !w_dec) begin
            if (r_pending == c_pend_max) begin
                w_ovf_d = 1'b1;
            end else begin
                w_pending_d = r_pending + PW'(1);
            end
        end else if (w_dec && !w_inc) begin
            w_pending_d = r_pending - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
            r_state    <= c_st_idle;
            r_timer    <= '0;
            r_pending  <= '0;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_ack_meta <= ack_in;
            r_ack_s    <= r_ack_meta;
            r_state    <= w_state_d;
            r_timer    <= w_timer_d;
            r_pending  <= w_pending_d;
            r_req      <= w_req_d;
            r_done     <= w_done_d;
            r_ovf      <= w_ovf_d;
            r_tmo      <= w_tmo_d;
        end
    end

    assign req_out     = r_req;
    assign busy        = (r_state != c_st_idle);
    assign pending     = r_pending;
    assign done_pulse  = r_done;
    assign overflow    = r_ovf;
    assign timeout_err = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_req_ack_pulse_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_ack_pulse_tx
//  Description : Self-checking bench for req_ack_pulse_tx. Directed scenarios
//                followed by randomized traffic, all compared every cycle
//                against a protocol-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_ack_pulse_tx;

    localparam int MAXP = 7;
    localparam int PW   = 3;
    localparam int TMO  = 20;
    localparam int TW   = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_pulse;
    logic          ack_in;
    logic          req_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          done_pulse;
    logic          overflow;
    logic          timeout_err;

    always #5 clk = ~clk;

    req_ack_pulse_tx #(
        .MAX_PENDING (MAXP),
        .PW          (PW),
        .TIMEOUT     (TMO),
        .TW          (TW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_pulse    (in_pulse),
        .ack_in      (ack_in),
        .req_out     (req_out),
        .busy        (busy),
        .pending     (pending),
        .done_pulse  (done_pulse),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: protocol view of the transmitter.
    //   m_req   : request level currently asserted toward the receiver
    //   m_drain : request dropped, waiting for the receiver's ack to clear
    //   m_abort : the drain in progress follows a timeout (no relaunch)
    int m_queue;
    int m_age;
    bit m_req, m_drain, m_abort;
    bit m_meta, m_acks;
    bit m_done, m_ovf, m_tmo;

    // Simple receiver: mirrors req_out onto ack_in after rx_lat cycles.
    bit rx_en  = 1'b0;
    int rx_lat = 3;
    int rx_cnt = 0;

    int n_done, n_ovf, n_tmo, max_pend;
    int pend_hist[$];
    int last_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit pulse, input bit ack);
        bit consumed, from_q, ready, arrival;
        consumed = 1'b0;
        from_q   = 1'b0;
        m_done   = 1'b0;
        m_ovf    = 1'b0;
        m_tmo    = 1'b0;
        if (!rst_n) begin
            m_queue = 0; m_age = 0;
            m_req = 0; m_drain = 0; m_abort = 0;
            m_meta = 0; m_acks = 0;
            return;
        end
        if (m_req) begin
            if (m_acks) begin
                m_req = 0; m_drain = 1; m_abort = 0; m_done = 1;
            end else if (m_age == TMO - 1) begin
                m_req = 0; m_drain = 1; m_abort = 1; m_tmo = 1;
            end else begin
                m_age++;
            end
        end else begin
            ready = !m_drain || (!m_acks && !m_abort);
            if (m_drain && !m_acks) begin
                m_drain = 0; m_abort = 0;
            end
            if (ready && (pulse || m_queue > 0)) begin
                m_req = 1; m_age = 0;
                if (m_queue == 0) consumed = 1'b1;
                else              from_q   = 1'b1;
            end
        end
        arrival = pulse && !consumed;
        if (arrival && !from_q) begin
            if (m_queue == MAXP) m_ovf = 1'b1;
            else                 m_queue++;
        end else if (from_q && !arrival) begin
            m_queue--;
        end
        m_acks = m_meta;
        m_meta = ack;
    endtask

    task automatic compare_all();
        check("req_out",     32'(req_out),     32'(m_req));
        check("busy",        32'(busy),        32'(m_req || m_drain));
        check("pending",     32'(pending),     32'(m_queue));
        check("done_pulse",  32'(done_pulse),  32'(m_done));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("timeout_err", 32'(timeout_err), 32'(m_tmo));
    endtask

    task automatic step(input bit pulse);
        in_pulse = pulse;
        if (rx_en) begin
            if (ack_in != req_out) begin
                rx_cnt++;
                if (rx_cnt >= rx_lat) begin
                    ack_in = req_out;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt = 0;
            end
        end
        @(posedge clk);
        model_step(reset_n, in_pulse, ack_in);
        @(negedge clk);
        compare_all();
        if (done_pulse === 1'b1)  n_done++;
        if (overflow === 1'b1)    n_ovf++;
        if (timeout_err === 1'b1) n_tmo++;
        if (int'(pending) > max_pend) max_pend = int'(pending);
        if (int'(pending) != last_pend) begin
            last_pend = int'(pending);
            pend_hist.push_back(last_pend);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ack_in  = 1'b0;
        rx_en   = 1'b0;
        rx_cnt  = 0;
        step(1'b0);
        step(1'b0);
        reset_n = 1'b1;
        n_done = 0; n_ovf = 0; n_tmo = 0; max_pend = 0;
        pend_hist.delete();
        last_pend = 0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((busy !== 1'b0 || pending !== '0) && k < 400) begin
            step(1'b0);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall;
        int exp_hist[6];
        reset_n  = 1'b0;
        in_pulse = 1'b0;
        ack_in   = 1'b0;
        m_queue = 0; m_age = 0; m_req = 0; m_drain = 0; m_abort = 0;
        m_meta = 0; m_acks = 0; m_done = 0; m_ovf = 0; m_tmo = 0;

        // Reset state
        do_reset();
        check("rst_req",  32'(req_out), 32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_pend", 32'(pending), 32'd0);

        // 1: single event, receiver acks after 3 cycles
        step(1'b1);
        check("t1_req_c1",  32'(req_out), 32'd1);
        check("t1_pend_c1", 32'(pending), 32'd0);
        rx_en = 1'b1; rx_lat = 3;
        drain("t1_idle");
        check("t1_done_cnt", 32'(n_done),   32'd1);
        check("t1_max_pend", 32'(max_pend), 32'd0);
        check("t1_req_end",  32'(req_out),  32'd0);

        // 2: burst of 4 with ack held low, then drained
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1);
        check("t2_pend_burst", 32'(pending), 32'd3);
        rx_en = 1'b1; rx_lat = 2;
        drain("t2_idle");
        check("t2_done_cnt", 32'(n_done), 32'd4);
        exp_hist = '{1, 2, 3, 2, 1, 0};
        check("t2_hist_len", 32'(pend_hist.size()), 32'd6);
        for (int i = 0; i < 6 && i < pend_hist.size(); i++)
            check("t2_hist", 32'(pend_hist[i]), 32'(exp_hist[i]));

        // 3: overflow, 9 pulses into a stalled handshake
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1);
        check("t3_ovf_pre", 32'(overflow), 32'd0);
        step(1'b1);
        check("t3_ovf_9th", 32'(overflow), 32'd1);
        check("t3_pend",    32'(pending),  32'd7);
        step(1'b0);
        check("t3_ovf_cnt", 32'(n_ovf),   32'd1);
        check("t3_pend_hold", 32'(pending), 32'd7);

        // 4: timeout with ack never rising
        do_reset();
        step(1'b1);
        fall = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0);
            if (fall == 0 && req_out === 1'b0) fall = k;
        end
        check("t4_fall_cycle", 32'(fall),   32'd20);
        check("t4_tmo_cnt",    32'(n_tmo),  32'd1);
        check("t4_done_cnt",   32'(n_done), 32'd0);
        check("t4_busy_end",   32'(busy),   32'd0);

        // 5: ack_s rises on the last timer cycle, ack wins
        do_reset();
        step(1'b1);
        for (int k = 1; k <= 19; k++) begin
            ack_in = (k >= 18);
            step(1'b0);
        end
        check("t5_req_c19", 32'(req_out),     32'd1);
        step(1'b0);
        check("t5_done",    32'(done_pulse),  32'd1);
        check("t5_no_tmo",  32'(timeout_err), 32'd0);
        ack_in = 1'b0;
        drain("t5_idle");
        check("t5_tmo_cnt", 32'(n_tmo), 32'd0);

        // 6: reset in the middle of a handshake with two queued
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1);
        check("t6_pend_pre", 32'(pending), 32'd2);
        reset_n = 1'b0;
        step(1'b0);
        check("t6_req_rst",  32'(req_out), 32'd0);
        check("t6_pend_rst", 32'(pending), 32'd0);
        check("t6_busy_rst", 32'(busy),    32'd0);
        reset_n = 1'b1;
        step(1'b1);
        check("t6_req_post",  32'(req_out), 32'd1);
        check("t6_pend_post", 32'(pending), 32'd0);
        rx_en = 1'b1; rx_lat = 1;
        drain("t6_idle");

        // Randomized traffic against the model
        for (int blk = 0; blk < 40; blk++) begin
            rx_en  = ($urandom_range(0, 4) != 0);
            rx_lat = $urandom_range(1, 6);
            for (int c = 0; c < 50; c++) begin
                reset_n = ($urandom_range(0, 299) != 0);
                step($urandom_range(0, 2) == 0);
            end
        end
        reset_n = 1'b1;
        rx_en   = 1'b1;
        rx_lat  = 2;
        drain("rand_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
